// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: program-counter/ROM side inputs and decode-side instruction outputs.
// The slave modport is the fetch unit; the master modport is the surrounding core or bench.
interface inst_fetch_if #(
  parameter int L = 10,
  parameter int W = 9
);
  logic         Start;
  logic [L-1:0] ProgCtr;
  logic         Taken;
  logic         Stall;
  logic [W-1:0] RomData;
  logic [L-1:0] RomAddr;
  logic         PcHold;
  logic [W-1:0] Instr;
  logic [L-1:0] InstrPC;
  logic         InstrValid;
  logic         Done;

  modport master (
    output Start, ProgCtr, Taken, Stall, RomData,
    input  RomAddr, PcHold, Instr, InstrPC, InstrValid, Done
  );

  modport slave (
    input  Start, ProgCtr, Taken, Stall, RomData,
    output RomAddr, PcHold, Instr, InstrPC, InstrValid, Done
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: issues ROM reads, buffers returned words in a 2-entry FIFO,
// and handles branch flushes and the halt opcode.
module inst_fetch #(
  parameter int           L       = 10,
  parameter int           W       = 9,
  parameter logic [W-1:0] HALT_OP = {W{1'b1}}
) (
  input  logic       Clk,
  input  logic       Reset,
  inst_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t       state_r, state_s;
  logic         done_r;
  logic         req_v_r;
  logic [L-1:0] req_pc_r;
  logic [W-1:0] fifo_data_r [2];
  logic [L-1:0] fifo_pc_r   [2];
  logic         wr_ptr_r, rd_ptr_r;
  logic [1:0]   count_r;

  logic         valid_s, pop_s, push_s, halt_pop_s, flush_s, issue_s, pc_hold_s;
  logic [2:0]   occ_s;

  assign bus.RomAddr    = bus.ProgCtr;
  assign bus.Instr      = fifo_data_r[rd_ptr_r];
  assign bus.InstrPC    = fifo_pc_r[rd_ptr_r];
  assign bus.InstrValid = valid_s;
  assign bus.PcHold     = pc_hold_s;
  assign bus.Done       = done_r;

  // Handshake decode: occupancy lookahead holds the PC before the FIFO could overflow
  always_comb begin
    valid_s    = (count_r != 2'd0);
    pop_s      = valid_s && !bus.Stall;
    halt_pop_s = pop_s && (state_r == RUN) && (fifo_data_r[rd_ptr_r] == HALT_OP);
    flush_s    = bus.Taken || halt_pop_s;
    push_s     = req_v_r && !flush_s;
    occ_s      = {1'b0, count_r} + {2'b00, req_v_r};
    pc_hold_s  = (state_r != RUN) || (occ_s >= (3'd2 + {2'b00, pop_s}));
    issue_s    = (state_r == RUN) && !pc_hold_s && !bus.Taken;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.Start) state_s = RUN;
        else            state_s = IDLE;
      end
      RUN: begin
        if (halt_pop_s) state_s = HALTED;
        else            state_s = RUN;
      end
      HALTED: begin
        if (bus.Start) state_s = IDLE;
        else           state_s = HALTED;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered Done flag
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == HALTED);
    end
  end

  // In-flight ROM request; a halt pop also drops the word issued alongside it
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      req_v_r  <= 1'b0;
      req_pc_r <= {L{1'b0}};
    end else begin
      req_v_r <= issue_s && !halt_pop_s;
      if (issue_s) req_pc_r <= bus.ProgCtr;
      else         req_pc_r <= req_pc_r;
    end
  end

  // Two-entry instruction FIFO with 1-bit wrapping pointers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_r       <= 1'b0;
      rd_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
      fifo_data_r[0] <= {W{1'b0}};
      fifo_data_r[1] <= {W{1'b0}};
      fifo_pc_r[0]   <= {L{1'b0}};
      fifo_pc_r[1]   <= {L{1'b0}};
    end else if (flush_s) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= bus.RomData;
        fifo_pc_r[wr_ptr_r]   <= req_pc_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= ~rd_ptr_r;
      else       rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: PC/ROM models around the DUT, scoreboard of expected
// {pc, instr} pairs checked on every pop, plus cycle-exact control checks.
module tb_inst_fetch;
  localparam int           L    = 10;
  localparam int           W    = 9;
  localparam logic [W-1:0] HALT = 9'h1FF;

  typedef struct {
    logic [L-1:0] pc;
    logic [W-1:0] ins;
  } exp_t;

  logic         Clk   = 1'b0;
  logic         Reset = 1'b0;
  logic [L-1:0] target;
  logic [W-1:0] rom [1024];
  exp_t         sb [$];
  exp_t         mon_e;
  int           vectors     = 0;
  int           miscompares = 0;

  inst_fetch_if #(.L(L), .W(W)) bus ();

  inst_fetch #(.L(L), .W(W), .HALT_OP(HALT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Program counter as the top level would build it (PcHold ORed into Start)
  always @(posedge Clk or negedge Reset) begin
    if (!Reset)                            bus.ProgCtr <= 10'd0;
    else if (bus.Taken)                    bus.ProgCtr <= target;
    else if (!(bus.PcHold || bus.Start))   bus.ProgCtr <= bus.ProgCtr + 10'd1;
  end

  // Synchronous ROM
  always @(posedge Clk) bus.RomData <= rom[bus.RomAddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int pc);
    exp_t e;
    e.pc  = pc[L-1:0];
    e.ins = rom[pc];
    sb.push_back(e);
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  // Scoreboard: every pop must match the next expected word
  always @(negedge Clk) begin
    if (Reset) begin
      chk("romaddr", bus.RomAddr, bus.ProgCtr);
      chk("no_push_when_full", dut.push_s && (dut.count_r == 2'd2), 1'b0);
      if (bus.InstrValid && !bus.Stall) begin
        chk("pop_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("pop_pc", bus.InstrPC, mon_e.pc);
          chk("pop_instr", bus.Instr, mon_e.ins);
        end
      end
    end
  end

  initial begin
    for (int a = 0; a < 1024; a++) rom[a] = a[W-1:0];
    bus.Start = 1'b1;
    bus.Taken = 1'b0;
    bus.Stall = 1'b0;
    target    = 10'd0;

    // Reset state
    repeat (2) @(posedge Clk);
    smp();
    chk("rst_valid", bus.InstrValid, 1'b0);
    chk("rst_hold", bus.PcHold, 1'b1);
    chk("rst_done", bus.Done, 1'b0);
    chk("rst_romaddr", bus.RomAddr, 10'd0);
    nxt(); Reset = 1'b1;
    smp(); chk("idle_hold", bus.PcHold, 1'b1);

    // Streaming run from PC 0
    nxt(); bus.Start = 1'b0;
    for (int k = 0; k <= 5; k++) push_exp(k);
    smp(); chk("c0_hold", bus.PcHold, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      nxt(); smp();
      chk("fill_valid", bus.InstrValid, (c >= 3));
      chk("stream_hold", bus.PcHold, 1'b0);
      if (c >= 3) chk("stream_pc", bus.InstrPC, c - 3);
    end

    // Four stalled cycles: buffer fills, head held
    for (int c = 7; c <= 10; c++) begin
      nxt(); bus.Stall = 1'b1;
      smp();
      chk("stall_hold", bus.PcHold, 1'b1);
      chk("stall_instr", bus.Instr, 9'd4);
      chk("stall_pc", bus.InstrPC, 10'd4);
    end
    nxt(); bus.Stall = 1'b0;
    smp(); chk("unstall_pc", bus.InstrPC, 10'd4); chk("unstall_hold", bus.PcHold, 1'b0);

    // Branch while PC 5 is at the head
    nxt(); bus.Taken = 1'b1; target = 10'd20;
    for (int k = 20; k <= 23; k++) push_exp(k);
    smp(); chk("taken_head", bus.InstrPC, 10'd5);
    nxt(); bus.Taken = 1'b0;
    smp(); chk("br_valid1", bus.InstrValid, 1'b0); chk("br_romaddr", bus.RomAddr, 10'd20);
    nxt(); smp(); chk("br_valid2", bus.InstrValid, 1'b0);
    nxt(); smp(); chk("br_target_valid", bus.InstrValid, 1'b1); chk("br_target_pc", bus.InstrPC, 10'd20);
    nxt(); smp(); nxt(); smp();

    // Async reset pulse with a full buffer
    nxt(); bus.Stall = 1'b1;
    smp(); chk("pre_full_hold", bus.PcHold, 1'b1);
    nxt(); smp(); chk("full_valid", bus.InstrValid, 1'b1);
    #2 Reset = 1'b0;
    #1 chk("arst_valid", bus.InstrValid, 1'b0); chk("arst_hold", bus.PcHold, 1'b1);
    sb.delete();
    bus.Start = 1'b1; bus.Stall = 1'b0;
    #1 Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nxt(); smp();
      chk("post_rst_valid", bus.InstrValid, 1'b0);
      chk("post_rst_done", bus.Done, 1'b0);
    end

    // Run into the halt opcode at address 8
    rom[8] = HALT;
    nxt(); bus.Start = 1'b0;
    for (int k = 0; k <= 8; k++) push_exp(k);
    smp();
    for (int c = 1; c <= 10; c++) begin
      nxt(); smp();
      chk("h_valid", bus.InstrValid, (c >= 3));
      chk("h_hold", bus.PcHold, 1'b0);
    end
    nxt(); smp();
    chk("halt_head", bus.InstrPC, 10'd8); chk("halt_instr", bus.Instr, HALT); chk("halt_done0", bus.Done, 1'b0);
    for (int c = 0; c < 2; c++) begin
      nxt(); smp();
      chk("halted_done", bus.Done, 1'b1);
      chk("halted_valid", bus.InstrValid, 1'b0);
      chk("halted_hold", bus.PcHold, 1'b1);
    end
    nxt(); bus.Start = 1'b1;
    smp(); chk("halted_done_s1", bus.Done, 1'b1);
    nxt(); smp(); chk("idle_done", bus.Done, 1'b0); chk("idle_hold2", bus.PcHold, 1'b1);

    // Branch coinciding with the halt pop
    nxt(); bus.Taken = 1'b1; target = 10'd6;
    smp();
    nxt(); bus.Taken = 1'b0; bus.Start = 1'b0;
    for (int k = 6; k <= 8; k++) push_exp(k);
    smp(); chk("reload_romaddr", bus.RomAddr, 10'd6);
    for (int c = 1; c <= 4; c++) begin nxt(); smp(); end
    nxt(); bus.Taken = 1'b1; target = 10'd30;
    smp(); chk("tk_halt_head", bus.InstrPC, 10'd8);
    nxt(); bus.Taken = 1'b0;
    smp(); chk("tk_halt_done", bus.Done, 1'b1); chk("tk_halt_valid", bus.InstrValid, 1'b0);
    for (int c = 0; c < 3; c++) begin
      nxt(); smp();
      chk("tk_halted_valid", bus.InstrValid, 1'b0);
      chk("tk_halted_done", bus.Done, 1'b1);
    end
    nxt(); bus.Start = 1'b1;
    smp(); smp();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter L, default 10: instruction address width, equal to the program counter width.
REQ-002 Parameter W, default 9: instruction word width.
REQ-003 Parameter HALT_OP, default all-ones of W bits: opcode that terminates the program.
REQ-004 Clk  in  1  single clock; all state changes on posedge Clk only.
REQ-005 Reset  in  1  asynchronous, active-low reset (Reset=0 clears all state immediately).
REQ-006 Start  in  1  high = hold/idle; the falling edge begins a program run.
REQ-007 ProgCtr  in  L  current program counter value.
REQ-008 Taken  in  1  branch taken this cycle; ProgCtr loads Target at the next edge.
REQ-009 Stall  in  1  decode cannot accept Instr this cycle.
REQ-010 RomData  in  W  synchronous ROM read data, valid one cycle after RomAddr.
REQ-011 RomAddr  out  L  ROM read address.
REQ-012 PcHold  out  1  request that the program counter hold its value (ORed into Start at top level).
REQ-013 Instr  out  W  instruction at the buffer head.
REQ-014 InstrPC  out  L  address of Instr.
REQ-015 InstrValid  out  1  Instr/InstrPC valid.
REQ-016 Done  out  1  program halted.

Function
REQ-017 RomAddr SHALL equal ProgCtr combinationally at all times.
REQ-018 State machine states: IDLE, RUN, HALTED.
- IDLE->RUN when Start=0.
- RUN->HALTED on a pop whose Instr==HALT_OP.
- HALTED->IDLE when Start=1.
- No other transitions.
REQ-019 issue = (state==RUN) && !PcHold && !Taken; on issue, the in-flight register SHALL capture req_v=1 and req_pc=ProgCtr; otherwise req_v=0.
REQ-020 A 2-entry FIFO of {RomData, req_pc} SHALL push at the edge following any cycle with req_v=1, unless a flush occurs at that edge.
REQ-021 pop = InstrValid && !Stall. Instr, InstrPC, and InstrValid SHALL present the FIFO head; InstrValid = (count != 0).
REQ-022 PcHold SHALL be 1 when state != RUN, or when count + req_v - pop >= 2; otherwise 0.
REQ-023 The block SHALL sustain one instruction per cycle with Stall=0 after a 2-cycle fill latency (ProgCtr at cycle t gives InstrValid at cycle t+2).
REQ-024 Flush: Taken=1 at an edge SHALL clear the FIFO (count=0) and req_v, discarding the in-flight word; the first target instruction SHALL appear 2 cycles after ProgCtr==Target.
REQ-025 Push and pop in the same cycle SHALL leave count unchanged; push with count==2 SHALL never occur (PcHold guarantees this; the bench asserts it).
REQ-026 A HALT_OP pop SHALL flush the FIFO and req_v, and assert Done from the next cycle until leaving HALTED.
REQ-027 Taken and a HALT_OP pop in the same cycle: the halt SHALL take priority (HALTED, flush).
REQ-028 The FIFO count SHALL stay in 0..2; pointers SHALL be 1 bit and wrap.

Reset
REQ-029 Reset=0 SHALL asynchronously force state=IDLE, count=0, pointers=0, req_v=0, req_pc=0, and Done=0; InstrValid=0 and PcHold=1 follow combinationally.
REQ-030 Reset asserted mid-run SHALL discard all buffered and in-flight words, and no push SHALL follow the reset release.

Verification
REQ-031 Reset, Start 1->0, ProgCtr increments from 0, ROM[a]=a, Stall=0 -> InstrValid first high at cycle 2 with Instr=0, InstrPC=0, then 1, 2, 3 on consecutive cycles, PcHold=0 throughout.
REQ-032 Stall=1 for 4 cycles mid-stream -> count reaches 2, PcHold=1, Instr held constant; on Stall=0, no word lost or duplicated (InstrPC sequence contiguous).
REQ-033 Taken=1 while InstrPC=5, ProgCtr then=20 -> words from PC 6/7 never appear; next InstrValid shows InstrPC=20 exactly 2 cycles after ProgCtr=20.
REQ-034 ROM[8]=HALT_OP -> on the pop of PC 8, Done=1 next cycle, InstrValid=0, PcHold=1; Start=1 -> IDLE, Done=0.
REQ-035 Reset=0 pulsed asynchronously between edges with count=2 -> InstrValid=0 immediately; after release with Start=1, no output until Start falls.
REQ-036 Taken and HALT_OP pop in the same cycle -> HALTED and Done=1; no target instruction emitted.
